pipeline_ctrl: RTL and testbench

//  Consumer of the load-use stall request, the MEM-stage branch-taken signal and data-memory wait.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and counter defaults.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        WAIT     = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr wins over en, holds at all-ones, never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Turns stall/branch/mem-wait requests into same-cycle per-stage enable/flush/bubble controls,
// tracks the last control mode in a small FSM, and keeps saturating event counters plus a sticky error.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             mem_wait,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             exmem_flush,
    output state_t           state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             hz_err
);

    state_t state_nxt;
    logic   stall_cyc;
    logic   flush_cyc;
    logic   hz_set;

    // A stall-type cycle is one where the load-use request is the winning cause.
    assign stall_cyc = stall_req && !branch_taken && !mem_wait;
    assign flush_cyc = branch_taken && !mem_wait;
    assign hz_set    = (state == LU_STALL) && stall_cyc;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        state_nxt   = RUN;

        // Reset gates the controls combinationally so the datapath is frozen the instant reset asserts.
        if (!reset) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (mem_wait) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_we   = 1'b0;
            exmem_we  = 1'b0;
            state_nxt = WAIT;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = FLUSH;
        end else if (stall_req) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = LU_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            hz_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr) begin
                hz_err <= 1'b0;
            end else if (hz_set) begin
                hz_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_cyc),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_cyc),
        .clr   (cnt_clr),
        .cnt   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (mem_wait),
        .clr   (cnt_clr),
        .cnt   (wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a 16-bit instance for control/FSM behaviour and a 4-bit one for saturation.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic stall_req, branch_taken, mem_wait, cnt_clr;

    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_flush, hz_err;
    state_t      state;
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;

    logic        pc_we4, ifid_we4, ifid_flush4, idex_we4, idex_bubble4, exmem_we4, exmem_flush4, hz_err4;
    state_t      state4;
    logic [3:0]  stall_cnt4, flush_cnt4, wait_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .cnt_clr(cnt_clr), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
        .exmem_we(exmem_we), .exmem_flush(exmem_flush), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt), .hz_err(hz_err)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .cnt_clr(cnt_clr), .pc_we(pc_we4), .ifid_we(ifid_we4),
        .ifid_flush(ifid_flush4), .idex_we(idex_we4), .idex_bubble(idex_bubble4),
        .exmem_we(exmem_we4), .exmem_flush(exmem_flush4), .state(state4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .wait_cnt(wait_cnt4), .hz_err(hz_err4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed control view: {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, exmem_flush}
    function automatic logic [31:0] ctl();
        return {25'd0, pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, exmem_flush};
    endfunction

    initial begin
        // 1: reset with every input high
        reset = 1'b0; stall_req = 1'b1; branch_taken = 1'b1; mem_wait = 1'b1; cnt_clr = 1'b1;
        #12;
        check("rst_ctl", ctl(), 32'b0000000);
        check("rst_state", state, RUN);
        check("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
        check("rst_wait_hz", {wait_cnt, 15'd0, hz_err}, 32'd0);
        stall_req = 1'b0; branch_taken = 1'b0; mem_wait = 1'b0; cnt_clr = 1'b0;
        @(negedge clk); reset = 1'b1;
        step();
        check("rel_state", state, RUN);
        check("rel_ctl", ctl(), 32'b1111000);

        // 2: single load-use stall
        stall_req = 1'b1; #1;
        check("stall_ctl", ctl(), 32'b0011010);
        step(); stall_req = 1'b0; #1;
        check("stall_state", state, LU_STALL);
        check("stall_cnt1", stall_cnt, 1);
        check("stall_hz0", hz_err, 0);

        // 3: two-cycle stall sets sticky hz_err
        step();
        check("run_again", state, RUN);
        stall_req = 1'b1; step(); step(); stall_req = 1'b0; #1;
        check("hz_set", hz_err, 1);
        check("stall_cnt3", stall_cnt, 3);
        step(); step();
        check("hz_sticky", hz_err, 1);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0; #1;
        check("hz_clr", hz_err, 0);
        check("clr_stall", stall_cnt, 0);

        // 4: branch beats stall
        branch_taken = 1'b1; stall_req = 1'b1; #1;
        check("br_ctl", ctl(), 32'b1111111);
        step(); branch_taken = 1'b0; stall_req = 1'b0; #1;
        check("br_state", state, FLUSH);
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 0);

        // 5: mem_wait freezes over a pending branch for 3 cycles
        mem_wait = 1'b1; branch_taken = 1'b1; #1;
        check("wait_ctl", ctl(), 32'b0000000);
        step(); step(); step();
        check("wait_state", state, WAIT);
        check("wait_cnt3", wait_cnt, 3);
        check("wait_flush_hold", flush_cnt, 1);
        mem_wait = 1'b0; #1;
        check("post_wait_ctl", ctl(), 32'b1111111);
        step(); branch_taken = 1'b0; #1;
        check("post_wait_state", state, FLUSH);
        check("post_wait_flush", flush_cnt, 2);
        check("post_wait_wcnt", wait_cnt, 3);

        // 6: 4-bit counter saturation, then clear while incrementing
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stall_req = 1'b1; step();
            stall_req = 1'b0; step();
            if (i == 14) check("sat_at15", stall_cnt4, 15);
        end
        check("sat_hold", stall_cnt4, 15);
        check("wide_cnt20", stall_cnt, 20);
        check("sat_no_hz", hz_err4, 0);
        stall_req = 1'b1; cnt_clr = 1'b1; step();
        stall_req = 1'b0; cnt_clr = 1'b0; #1;
        check("sat_clr", stall_cnt4, 0);
        check("wide_clr", stall_cnt, 0);

        // Async reset mid-operation, then restart from RUN
        mem_wait = 1'b1; step(); step();
        check("pre_rst_state", state, WAIT);
        @(negedge clk); #2; reset = 1'b0; #1;
        check("async_state", state, RUN);
        check("async_wcnt", wait_cnt, 0);
        check("async_ctl", ctl(), 32'b0000000);
        mem_wait = 1'b0; stall_req = 1'b1;
        @(negedge clk); reset = 1'b1;
        step(); stall_req = 1'b0; #1;
        check("rerun_state", state, LU_STALL);
        check("rerun_hz", hz_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
